// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : CPU-side load/store handshake between the RV32I datapath
//                and mem_access_unit.
//                master = CPU datapath, slave = mem_access_unit.
//    req_i    : request strobe, sampled only while ready_o=1
//    we_i     : 1=store, 0=load
//    funct3_i : RV32I load/store funct3
//    addr_i   : byte address
//    wdata_i  : store data (low bytes used for SB/SH)
//    ready_o  : unit idle, can accept a request
//    done_o   : one-cycle completion pulse
//    fault_o  : valid with done_o, request misaligned or illegal
//    rdata_o  : extended load result, valid from done_o onward
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_i;
  logic                  we_i;
  logic [2:0]            funct3_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           wdata_i;
  logic                  ready_o;
  logic                  done_o;
  logic                  fault_o;
  logic [31:0]           rdata_o;

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i,
    input  ready_o, done_o, fault_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i,
    output ready_o, done_o, fault_o, rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store front end between the RV32I multicycle datapath
//                and a word-addressed BRAM with active-low rd/wr strobes.
//                Byte-lane extraction with sign/zero extension for loads,
//                read-modify-write for SB/SH, fault flag for misaligned or
//                illegal requests.
//  Ports       : clk_i, reset_i   clock, synchronous active-high reset
//                cpu              CPU handshake (mem_access_unit_if.slave)
//                mem_addr_o       word address to the memory
//                mem_data_o       write data to the memory
//                mem_rd_no        memory read enable, active low
//                mem_wr_no        memory write enable, active low
//                mem_data_i       memory read data (captured on negedge)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int WORDS      = 10,
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic             clk_i,
  input  wire logic             reset_i,
  mem_access_unit_if.slave      cpu,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [31:0]           mem_data_o,
  output logic                  mem_rd_no,
  output logic                  mem_wr_no,
  input  wire logic [31:0]      mem_data_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [WORDS-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]        mem_data_q, mem_data_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               fault_q, fault_d;

  // Address bits above the word index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu.addr_i[ADDR_WIDTH-1:WORDS+2];

  // Request decode on the live CPU inputs (only meaningful in IDLE).
  logic       req_legal;
  logic       req_misaligned;
  logic [1:0] req_off;
  assign req_off = cpu.addr_i[1:0];

  always_comb begin
    req_legal = 1'b0;
    if (cpu.we_i) begin
      req_legal = (cpu.funct3_i == 3'b000) || (cpu.funct3_i == 3'b001) ||
                  (cpu.funct3_i == 3'b010);
    end else begin
      req_legal = (cpu.funct3_i == 3'b000) || (cpu.funct3_i == 3'b001) ||
                  (cpu.funct3_i == 3'b010) || (cpu.funct3_i == 3'b100) ||
                  (cpu.funct3_i == 3'b101);
    end
    // funct3[1:0] encodes access size: 01 halfword, 10 word.
    req_misaligned = ((cpu.funct3_i[1:0] == 2'b01) && req_off[0]) ||
                     ((cpu.funct3_i[1:0] == 2'b10) && (req_off != 2'b00));
  end

  // Lane handling on the word returned by the memory.
  logic [4:0]  lane_shift;
  logic [31:0] lane_data;
  logic [31:0] load_value;
  logic [31:0] merge_mask;
  logic [31:0] merge_value;

  assign lane_shift = {off_q, 3'b000};
  assign lane_data  = mem_data_i >> lane_shift;

  always_comb begin
    case (funct3_q)
      3'b000:  load_value = {{24{lane_data[7]}},  lane_data[7:0]};
      3'b001:  load_value = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_value = {24'h000000, lane_data[7:0]};
      3'b101:  load_value = {16'h0000,   lane_data[15:0]};
      default: load_value = mem_data_i;
    endcase

    // Halfword alignment is guaranteed, so off_q[0] is 0 for SH.
    if (funct3_q[0]) begin
      merge_mask  = 32'h0000_FFFF << lane_shift;
      merge_value = {16'h0000, wdata_q[15:0]} << lane_shift;
    end else begin
      merge_mask  = 32'h0000_00FF << lane_shift;
      merge_value = {24'h000000, wdata_q[7:0]} << lane_shift;
    end
  end

  // Next-state and next-register computation.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;

    case (state_q)
      S_IDLE: begin
        if (cpu.req_i) begin
          we_d       = cpu.we_i;
          funct3_d   = cpu.funct3_i;
          off_d      = req_off;
          wdata_d    = cpu.wdata_i;
          mem_addr_d = cpu.addr_i[WORDS+1:2];
          if (!req_legal || req_misaligned) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            fault_d = 1'b0;
            if (cpu.we_i && (cpu.funct3_i == 3'b010)) begin
              // Full-word store needs no read of the old contents.
              mem_data_d = cpu.wdata_i;
              state_d    = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          mem_data_d = (mem_data_i & ~merge_mask) | merge_value;
          state_d    = S_WRITE;
        end else begin
          rdata_d = load_value;
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
      end
      default: begin
        // fault_q is only ever high during the DONE cycle.
        fault_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      mem_addr_q <= '0;
      mem_data_q <= 32'h0;
      rdata_q    <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
    end
  end

  // Moore decodes of the state register; at most one strobe low at a time.
  assign mem_rd_no   = (state_q != S_READ);
  assign mem_wr_no   = (state_q != S_WRITE);
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign cpu.ready_o = (state_q == S_IDLE);
  assign cpu.done_o  = (state_q == S_DONE);
  assign cpu.fault_o = fault_q;
  assign cpu.rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit with a negedge
//                BRAM model and a word-level reference model of memory
//                contents, load results, faults, latency and strobe usage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int WORDS      = 10;
  localparam int ADDR_WIDTH = 32;
  localparam int DEPTH      = 1 << WORDS;

  logic              clk;
  logic              reset_i;
  logic [WORDS-1:0]  mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              mem_rd_no;
  logic              mem_wr_no;
  logic [31:0]       mem_data_i;

  mem_access_unit_if #(.ADDR_WIDTH(ADDR_WIDTH)) cpu ();

  mem_access_unit #(.WORDS(WORDS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .cpu        (cpu.slave),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_rd_no  (mem_rd_no),
    .mem_wr_no  (mem_wr_no),
    .mem_data_i (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: read and write both happen on the mid-cycle negedge.
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(negedge clk) begin
    if (!mem_rd_no) mem_data_i <= mem[mem_addr_o];
    if (!mem_wr_no) mem[mem_addr_o] <= mem_data_o;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rand_cpu_inputs();
    cpu.we_i     = 1'($urandom);
    cpu.funct3_i = 3'($urandom);
    cpu.addr_i   = $urandom;
    cpu.wdata_i  = $urandom;
  endtask

  // Reference model: updates ref_mem / exp_rdata and returns the expected
  // fault flag, latency and number of read/write cycles.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic fault, output int lat,
                       output int rds, output int wrs);
    int          w, off, sh;
    logic [31:0] word, b, h;
    logic        legal, mis;
    w    = int'(a[11:2]);
    off  = int'(a[1:0]);
    sh   = 8 * off;
    word = ref_mem[w];
    legal = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    mis   = (f3[1:0] == 2'd1 && (off % 2) != 0) || (f3[1:0] == 2'd2 && off != 0);
    fault = !legal || mis;
    rds = 0; wrs = 0;
    if (fault) begin
      lat = 1;
    end else if (!we) begin
      lat = 2; rds = 1;
      b = (word >> sh) % 256;
      h = (word >> sh) % 65536;
      case (f3)
        3'd0:    exp_rdata = (b >= 128) ? b - 32'd256 : b;
        3'd1:    exp_rdata = (h >= 32768) ? h - 32'd65536 : h;
        3'd4:    exp_rdata = b;
        3'd5:    exp_rdata = h;
        default: exp_rdata = word;
      endcase
    end else if (f3 == 3'd2) begin
      lat = 2; wrs = 1;
      ref_mem[w] = wd;
    end else begin
      lat = 3; rds = 1; wrs = 1;
      if (f3 == 3'd0) begin
        b = (word >> sh) % 256;
        ref_mem[w] = word - (b << sh) + ((wd % 256) << sh);
      end else begin
        h = (word >> sh) % 65536;
        ref_mem[w] = word - (h << sh) + ((wd % 65536) << sh);
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic hold_req);
    logic fault_e;
    int   lat_e, rds_e, wrs_e, edges, rds, wrs, both;
    int   waited;
    waited = 0;
    while (!cpu.ready_o && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cpu.ready_o) begin
      check("ready_wait", 32'(cpu.ready_o), 32'd1);
      return;
    end
    model(we, f3, a, wd, fault_e, lat_e, rds_e, wrs_e);
    cpu.req_i = 1'b1; cpu.we_i = we; cpu.funct3_i = f3; cpu.addr_i = a; cpu.wdata_i = wd;
    @(posedge clk);          // acceptance edge E0
    edges = 0; rds = 0; wrs = 0; both = 0;
    forever begin
      #1;
      edges++;
      if (!hold_req) cpu.req_i = 1'b0;
      rand_cpu_inputs();
      if (!mem_rd_no) rds++;
      if (!mem_wr_no) wrs++;
      if (!mem_rd_no && !mem_wr_no) both++;
      if (cpu.done_o || edges >= 10) break;
      @(posedge clk);
    end
    cpu.req_i = 1'b0;
    check("done_latency", 32'(edges), 32'(lat_e));
    check("fault",        32'(cpu.fault_o), 32'(fault_e));
    check("rdata",        cpu.rdata_o, exp_rdata);
    check("read_cycles",  32'(rds), 32'(rds_e));
    check("write_cycles", 32'(wrs), 32'(wrs_e));
    check("both_strobes", 32'(both), 32'd0);
    check("mem_word",     mem[a[11:2]], ref_mem[a[11:2]]);
    @(posedge clk); #1;
    check("ready_after",  32'(cpu.ready_o), 32'd1);
    check("done_pulse",   32'(cpu.done_o), 32'd0);
  endtask

  initial begin
    int bad_words, wr_seen;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[10] = 32'h55AA3312; ref_mem[10] = 32'h55AA3312;
    mem[14] = 32'hBBAA1136; ref_mem[14] = 32'hBBAA1136;
    mem_data_i = 32'h0;
    cpu.req_i = 1'b0; cpu.we_i = 1'b0; cpu.funct3_i = 3'd0; cpu.addr_i = '0; cpu.wdata_i = '0;
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cpu.ready_o), 32'd1);
    check("rst_done",  32'(cpu.done_o),  32'd0);
    check("rst_fault", 32'(cpu.fault_o), 32'd0);
    check("rst_rdata", cpu.rdata_o, 32'h0);
    check("rst_rd_n",  32'(mem_rd_no), 32'd1);
    check("rst_wr_n",  32'(mem_wr_no), 32'd1);
    check("rst_addr",  32'(mem_addr_o), 32'd0);
    check("rst_wdata", mem_data_o, 32'h0);
    reset_i = 1'b0;

    // Directed loads.
    do_req(1'b0, 3'd0, 32'h2A, 32'h0, 1'b0); check("lb_2a",  cpu.rdata_o, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 32'h2A, 32'h0, 1'b1); check("lbu_2a", cpu.rdata_o, 32'h000000AA);
    do_req(1'b0, 3'd0, 32'h2B, 32'h0, 1'b0); check("lb_2b",  cpu.rdata_o, 32'h00000055);
    do_req(1'b0, 3'd1, 32'h3A, 32'h0, 1'b0); check("lh_3a",  cpu.rdata_o, 32'hFFFFBBAA);
    do_req(1'b0, 3'd5, 32'h3A, 32'h0, 1'b0); check("lhu_3a", cpu.rdata_o, 32'h0000BBAA);
    do_req(1'b0, 3'd1, 32'h38, 32'h0, 1'b0); check("lh_38",  cpu.rdata_o, 32'h00001136);
    do_req(1'b0, 3'd2, 32'h38, 32'h0, 1'b0); check("lw_38",  cpu.rdata_o, 32'hBBAA1136);
    // Directed stores.
    do_req(1'b1, 3'd0, 32'h29, 32'h000000EE, 1'b1); check("sb_29", mem[10], 32'h55AAEE12);
    do_req(1'b1, 3'd1, 32'h3A, 32'h00001234, 1'b0); check("sh_3a", mem[14], 32'h12341136);
    do_req(1'b1, 3'd2, 32'h50, 32'hDEADBEEF, 1'b0); check("sw_50", mem[20], 32'hDEADBEEF);
    // Faults.
    do_req(1'b0, 3'd2, 32'h2A, 32'h0, 1'b0);
    do_req(1'b1, 3'd1, 32'h29, 32'hFFFF, 1'b0);
    do_req(1'b0, 3'd3, 32'h28, 32'h0, 1'b0);
    do_req(1'b1, 3'd4, 32'h28, 32'h0, 1'b0);
    check("fault_rdata_kept", cpu.rdata_o, 32'hBBAA1136);

    // Reset while SB sits in READ: no write may follow.
    cpu.req_i = 1'b1; cpu.we_i = 1'b1; cpu.funct3_i = 3'd0; cpu.addr_i = 32'h28; cpu.wdata_i = 32'h77;
    @(posedge clk); #1;
    cpu.req_i = 1'b0;
    check("rst_mid_in_read", 32'(mem_rd_no), 32'd0);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    exp_rdata = 32'h0;
    check("rst_mid_ready", 32'(cpu.ready_o), 32'd1);
    check("rst_mid_rdata", cpu.rdata_o, 32'h0);
    check("rst_mid_addr",  32'(mem_addr_o), 32'd0);
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (!mem_wr_no) wr_seen++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_write", 32'(wr_seen), 32'd0);
    check("rst_mid_word10",   mem[10], 32'h55AAEE12);

    // Randomized traffic over a small window so loads hit prior stores.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = $urandom_range(0, 127) | ({$urandom} << 12);
      do_req(1'($urandom), 3'($urandom), a, $urandom, 1'($urandom));
    end

    bad_words = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) bad_words++;
    check("mem_final", 32'(bad_words), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end between the RV32I multicycle datapath and the 1K×32 word-addressed BRAM `Memory` block. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses using that block's active-low rd/wr strobes. Loads get byte-lane extraction and sign/zero extension. Sub-word stores are done as read-modify-write, and the unit flags misaligned or illegal requests.

Parameters:
WORDS, 10, log2 of memory depth in words; must match the attached `Memory` instance.
ADDR_WIDTH, 32, width of the CPU byte address.

Ports:
clk_i  input  1  clock; all state updates on posedge.
reset_i  input  1  synchronous reset, active-high.
req_i  input  1  request strobe; sampled only when ready_o=1.
we_i  input  1  1=store, 0=load.
funct3_i  input  3  RV32I load/store funct3.
addr_i  input  ADDR_WIDTH  byte address.
wdata_i  input  32  store data (low bytes used for SB/SH).
ready_o  output  1  unit idle, can accept a request.
done_o  output  1  one-cycle completion pulse.
fault_o  output  1  valid with done_o; request was misaligned or illegal.
rdata_o  output  32  extended load result; valid from done_o onward.
mem_addr_o  output  WORDS  word address to `Memory`.
mem_data_o  output  32  write data to `Memory`.
mem_rd_no  output  1  `Memory` read enable, active low.
mem_wr_no  output  1  `Memory` write enable, active low.
mem_data_i  input  32  `Memory` read data; registered on negedge.

Behaviour:
- States: IDLE, READ, WRITE, DONE. All mem_* outputs are Moore decodes of the state register and latched request registers.
  - mem_rd_no=0 only in READ.
  - mem_wr_no=0 only in WRITE.
  - ready_o=1 only in IDLE.
- Reset values: state IDLE, ready_o=1, done_o=0, fault_o=0, rdata_o=0, mem_rd_no=1, mem_wr_no=1, mem_addr_o=0, mem_data_o=0.
- Request acceptance (IDLE with req_i=1), at posedge E0:
  - Latch we, funct3, addr, wdata.
  - mem_addr_o = addr[WORDS+1:2]; higher address bits are ignored.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- Transitions from IDLE:
  - Fault (illegal or misaligned) → DONE with fault; no strobe is ever asserted; rdata_o unchanged.
  - Load → READ.
  - SW → WRITE with mem_data_o=wdata.
  - SB/SH → READ.
- READ: `Memory` captures on the mid-cycle negedge, so mem_data_i is valid at the next posedge E1.
  - Load: at E1 extract the lane into rdata_o and go to DONE.
  - SB/SH: at E1 build mem_data_o = mem_data_i with the addressed byte (addr[1:0]) or halfword (addr[1]) replaced by wdata[7:0]/wdata[15:0]; go to WRITE.
- WRITE: lasts one cycle, then DONE.
- DONE: done_o=1 for exactly one cycle, fault_o set accordingly; next state IDLE.
- Lane rules:
  - Little-endian; byte n = bits [8n+7:8n].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Latency, counted as edges from the acceptance edge E0 to done_o rising:
  - Fault: 1.
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
- Throughput: next request accepted in the IDLE cycle that follows DONE.
- req_i is ignored when ready_o=0.
- Inputs other than req_i may change freely after acceptance.
- Reset mid-operation: the next posedge forces IDLE and all outputs to reset values.
  - If reset asserts while in WRITE, the negedge write inside that cycle has already occurred; this is required behaviour.
  - If reset asserts in READ of SB/SH, no write is issued.
- Only one strobe is ever low at a time. At most one read and one write per request.

Test Plan:
- Preload word 10 = 0x55AA3312. LB 0x2A → rdata 0xFFFFFFAA; LBU 0x2A → 0x000000AA; LB 0x2B → 0x00000055. done_o 2 edges after acceptance.
- Preload word 14 = 0xBBAA1136. LH 0x3A → 0xFFFFBBAA; LHU 0x3A → 0x0000BBAA; LH 0x38 → 0x00001136; LW 0x38 → 0xBBAA1136.
- SB addr 0x29, wdata 0x000000EE, on word 10 = 0x55AA3312 → word becomes 0x55AAEE12. mem_rd_no low exactly 1 cycle, then mem_wr_no low exactly 1 cycle; done_o 3 edges after acceptance.
- SH addr 0x3A, wdata 0x1234 on word 14 → 0x12341136. SW addr 0x50, wdata 0xDEADBEEF → word 20 = 0xDEADBEEF with no read cycle; done_o at 2 edges.
- LW 0x2A, SH 0x29, and funct3 011 each → done_o and fault_o 1 edge after acceptance; both strobes stay high; rdata_o and memory unchanged.
- reset_i asserted during READ of SB to 0x28 → IDLE and ready_o=1 after that edge, mem_wr_no never low, word 10 unchanged. req_i held while busy is not accepted.
